wb_8to16_bridge: RTL

//  Registered Wishbone bridge: 8-bit master (CPU/DMA byte port) onto a 16-bit slave (SDRAM ctrl, video RAM).
//  One outstanding access; steers the byte to the lane given by adr[0] and extracts the read byte.

---
 rtl/wb_8to16_bridge_pkg.sv | 28 ++
 rtl/wb_8to16_bridge_if.sv | 43 ++++
 rtl/wb_8to16_bridge_timeout_cnt.sv | 41 ++++
 rtl/wb_8to16_bridge.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/wb_8to16_bridge_pkg.sv
// Shared types and lane helpers for the 8-to-16 Wishbone bridge.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package wb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } bridge_state_t;

  typedef enum logic [1:0] {
    RSP_ACK = 2'd0,
    RSP_ERR = 2'd1,
    RSP_RTY = 2'd2
  } bridge_rsp_t;

  // Byte lane enable for a single-byte access: odd address -> upper lane.
  function automatic logic [1:0] lane_sel(input logic adr0);
    return adr0 ? 2'b10 : 2'b01;
  endfunction

  // Pick the addressed byte out of a 16-bit word.
  function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic adr0);
    return adr0 ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/wb_8to16_bridge_if.sv
// Bundle of the 8-bit master side and 16-bit slave side of the bridge.
// Latency: n/a (wires only).
// Backpressure: Wishbone classic; requester holds stb until ack/err/rty.
// Signal suffixes are from the bridge's point of view: modport slave is the
// bridge itself, modport master is the surrounding system (CPU + 16-bit slave).
interface wb_8to16_bridge_if #(
  parameter int ADDR_W = 20
);
  logic              m8_cyc_i;
  logic              m8_stb_i;
  logic              m8_we_i;
  logic [ADDR_W-1:0] m8_adr_i;
  logic [7:0]        m8_dat_i;
  logic [7:0]        m8_dat_o;
  logic              m8_ack_o;
  logic              m8_err_o;
  logic              m8_rty_o;
  logic              s16_cyc_o;
  logic              s16_stb_o;
  logic              s16_we_o;
  logic [ADDR_W-1:0] s16_adr_o;
  logic [1:0]        s16_sel_o;
  logic [15:0]       s16_dat_o;
  logic [15:0]       s16_dat_i;
  logic              s16_ack_i;
  logic              s16_err_i;
  logic              s16_rty_i;

  modport slave (
    input  m8_cyc_i, m8_stb_i, m8_we_i, m8_adr_i, m8_dat_i,
    input  s16_dat_i, s16_ack_i, s16_err_i, s16_rty_i,
    output m8_dat_o, m8_ack_o, m8_err_o, m8_rty_o,
    output s16_cyc_o, s16_stb_o, s16_we_o, s16_adr_o, s16_sel_o, s16_dat_o
  );

  modport master (
    output m8_cyc_i, m8_stb_i, m8_we_i, m8_adr_i, m8_dat_i,
    output s16_dat_i, s16_ack_i, s16_err_i, s16_rty_i,
    input  m8_dat_o, m8_ack_o, m8_err_o, m8_rty_o,
    input  s16_cyc_o, s16_stb_o, s16_we_o, s16_adr_o, s16_sel_o, s16_dat_o
  );

endinterface

// File: rtl/wb_8to16_bridge_timeout_cnt.sv
// Bus watchdog: counts enabled cycles, flags the LIMIT-th one; LIMIT=0 never expires.
// Latency: expired_o is combinational on the cycle that completes LIMIT counts.
// Backpressure: none; clear_i has priority over en_i.
module wb_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [W-1:0] LAST = (LIMIT > 0) ? W'(LIMIT - 1) : '0;

  logic [W-1:0] cnt_q, cnt_d;

  // Count enabled cycles; saturate at LAST so a held enable never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the cycles already counted, so this cycle is number cnt_q+1.
  assign expired_o = (LIMIT > 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/wb_8to16_bridge.sv
// Registered Wishbone bridge: 8-bit byte master onto a 16-bit slave, one access in flight, bus timeout.
// Latency: request N -> s16_stb N+1 -> m8 response N+2 (zero-wait slave); cache hit responds at N+1.
// Backpressure: master holds stb until response; slave waits stretch BUS up to TIMEOUT cycles.
// Optional feature: define READ_CACHE_EN for a one-word read cache (side-effect-free slaves only).
module wb_8to16_bridge
  import wb_bridge_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int TIMEOUT = 255
) (
  input logic               clk_i,
  input logic               rst_i,
  wb_8to16_bridge_if.slave  bus
);

  bridge_state_t     state_q, state_d;
  bridge_rsp_t       rsp_q, rsp_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic              we_q, we_d;
  logic [7:0]        dat_q, dat_d;
  logic [1:0]        sel_q, sel_d;
  logic [7:0]        rdat_q, rdat_d;
  logic              tmo_expired;

`ifdef READ_CACHE_EN
  logic              cvld_q, cvld_d;
  logic [ADDR_W-2:0] ctag_q, ctag_d;
  logic [15:0]       cdat_q, cdat_d;
  logic [ADDR_W-2:0] req_tag, cur_tag;

  assign req_tag = bus.m8_adr_i[ADDR_W-1:1];
  assign cur_tag = adr_q[ADDR_W-1:1];
`endif

  wb_timeout_cnt #(
    .LIMIT (TIMEOUT)
  ) u_tmo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (state_q != BUS),
    .en_i      (state_q == BUS),
    .expired_o (tmo_expired)
  );

  // Access FSM: latch request, run slave cycle, then a single response cycle.
  always_comb begin
    state_d = state_q;
    rsp_d   = rsp_q;
    adr_d   = adr_q;
    we_d    = we_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    rdat_d  = rdat_q;
`ifdef READ_CACHE_EN
    cvld_d  = cvld_q;
    ctag_d  = ctag_q;
    cdat_d  = cdat_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.m8_cyc_i && bus.m8_stb_i) begin
          adr_d   = bus.m8_adr_i;
          we_d    = bus.m8_we_i;
          dat_d   = bus.m8_dat_i;
          sel_d   = lane_sel(bus.m8_adr_i[0]);
          rsp_d   = RSP_ACK;
          rdat_d  = '0;
          state_d = BUS;
`ifdef READ_CACHE_EN
          if (bus.m8_we_i) begin
            // A write makes the cached copy stale; it is never merged.
            if (req_tag == ctag_q) cvld_d = 1'b0;
          end else if (cvld_q && (req_tag == ctag_q)) begin
            rdat_d  = lane_byte(cdat_q, bus.m8_adr_i[0]);
            state_d = RESP;
          end else begin
            // Fetch the whole word so the other byte can hit later.
            sel_d = 2'b11;
          end
`endif
        end
      end
      BUS: begin
        if (!bus.m8_cyc_i) begin
          // Master abandoned the cycle: release the slave, say nothing.
          state_d = IDLE;
        end else if (bus.s16_err_i) begin
          rsp_d   = RSP_ERR;
          rdat_d  = '0;
          state_d = RESP;
`ifdef READ_CACHE_EN
          cvld_d  = 1'b0;
`endif
        end else if (bus.s16_rty_i) begin
          rsp_d   = RSP_RTY;
          rdat_d  = '0;
          state_d = RESP;
`ifdef READ_CACHE_EN
          if (cur_tag == ctag_q) cvld_d = 1'b0;
`endif
        end else if (bus.s16_ack_i) begin
          rsp_d   = RSP_ACK;
          rdat_d  = we_q ? 8'h00 : lane_byte(bus.s16_dat_i, adr_q[0]);
          state_d = RESP;
`ifdef READ_CACHE_EN
          if (!we_q) begin
            cvld_d = 1'b1;
            ctag_d = cur_tag;
            cdat_d = bus.s16_dat_i;
          end
`endif
        end else if (tmo_expired) begin
          rsp_d   = RSP_ERR;
          rdat_d  = '0;
          state_d = RESP;
`ifdef READ_CACHE_EN
          if (cur_tag == ctag_q) cvld_d = 1'b0;
`endif
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bridge state registers; reset drops any access in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rsp_q   <= RSP_ACK;
      adr_q   <= '0;
      we_q    <= 1'b0;
      dat_q   <= '0;
      sel_q   <= '0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      rdat_q  <= rdat_d;
    end
  end

`ifdef READ_CACHE_EN
  // Read cache registers; reset invalidates.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cvld_q <= 1'b0;
      ctag_q <= '0;
      cdat_q <= '0;
    end else begin
      cvld_q <= cvld_d;
      ctag_q <= ctag_d;
      cdat_q <= cdat_d;
    end
  end
`endif

  logic in_resp;
  assign in_resp = (state_q == RESP);

  assign bus.s16_cyc_o = (state_q == BUS);
  assign bus.s16_stb_o = (state_q == BUS);
  assign bus.s16_we_o  = we_q;
  assign bus.s16_adr_o = adr_q;
  assign bus.s16_sel_o = sel_q;
  assign bus.s16_dat_o = {dat_q, dat_q};

  assign bus.m8_ack_o  = in_resp && (rsp_q == RSP_ACK);
  assign bus.m8_err_o  = in_resp && (rsp_q == RSP_ERR);
  assign bus.m8_rty_o  = in_resp && (rsp_q == RSP_RTY);
  assign bus.m8_dat_o  = (in_resp && (rsp_q == RSP_ACK)) ? rdat_q : 8'h00;

endmodule
